bpsk_packet_decoder: RTL and testbench
======================================

// Module: bpsk_packet_decoder
// PURPOSE
// - Parametrised BPSK packet decoder. Sits downstream of the carrier/phase-recovery path and consumes signed baseband
//   samples on AXIS. On a sync trigger it integrates a centred window of each symbol (integrate-and-dump), slices the
//   sign to a bit and assembles PACKET_LENGTH bits into one AXIS word for the downstream FIFO.
// - Adds three things to the single-sample slicer: tvalid-gated sample counting, m00 backpressure through a one-deep
//   holding register, and an overflow flag.
// PARAMETERS
// - DATA_WIDTH          16   sample width, two's complement (s00_axis_tdata)
// - PACKET_LENGTH       128  bits per packet = m00_axis_tdata width; multiple of 8, >=2
// - SAMPLES_PER_SYMBOL  32   valid samples per symbol; >=2
// - WINDOW              16   samples integrated per symbol; even, 2..SAMPLES_PER_SYMBOL
// - START_OFFSET        3    valid samples discarded after trigger before symbol 0 starts; 0..255
// PORTS
// - s00_axis_aclk     in   1                   clock
// - s00_axis_areset   in   1                   reset, asynchronous, active-high
// - s00_axis_tdata    in   DATA_WIDTH          signed sample
// - s00_axis_tvalid   in   1                   sample valid
// - s00_axis_tlast    in   1                   ignored
// - s00_axis_tready   out  1                   constant 1
// - trigger_valid     in   1                   1-cycle pulse: preamble detected, start packet
// - trigger_polarity  in   1                   phase ambiguity; 1 inverts every decoded bit
// - abort             in   1                   drop the packet in progress, return to IDLE
// - m00_axis_tdata    out  PACKET_LENGTH       packet; first bit received in MSB
// - m00_axis_tvalid   out  1                   packet valid
// - m00_axis_tready   in   1                   downstream ready
// - m00_axis_tlast    out  1                   = m00_axis_tvalid
// - m00_axis_tstrb    out  PACKET_LENGTH/8     all ones
// - overflow          out  1                   sticky; a packet completed while the holding register was full
// - busy              out  1                   1 when state != IDLE
// BEHAVIOUR
// - Reset (async, active-high)
//   - state=IDLE; counters, accumulator, shift register and m00_axis_tdata = 0.
//   - m00_axis_tvalid=0, overflow=0, busy=0. Any pending output is lost.
// - Counting: only cycles with s00_axis_tvalid=1 advance any counter or accumulator.
// - FSM IDLE -> SKIP -> RECORD -> IDLE
//   - IDLE: trigger_valid=1 latches polarity, clears counters and shift register.
//     Next state is SKIP, or RECORD if START_OFFSET=0.
//   - SKIP: discards START_OFFSET valid samples, then enters RECORD.
//   - RECORD: sample index s runs 0..SAMPLES_PER_SYMBOL-1 and wraps to 0 with bit index +1.
//     - Accumulator (width DATA_WIDTH+$clog2(WINDOW)+1, sign-extended) adds samples with
//       s in [SAMPLES_PER_SYMBOL/2-WINDOW/2, SAMPLES_PER_SYMBOL/2+WINDOW/2-1].
//     - At s=SAMPLES_PER_SYMBOL-1: bit=(acc_final>=0)^polarity; shift in at LSB; acc cleared.
//       acc_final includes the current sample if it is in the window.
//     - After bit PACKET_LENGTH-1: packet complete -> IDLE.
//   - trigger_valid outside IDLE is ignored. abort outside IDLE -> IDLE next cycle, no output.
//     abort has priority over a same-cycle completion.
// - Output holding register
//   - On completion with m00_axis_tvalid=0 or (tvalid & tready) the same cycle: load tdata, tvalid=1 next cycle.
//     Latency: 1 cycle after the final valid sample.
//   - On completion with tvalid=1 & tready=0: packet dropped, overflow<=1, held word unchanged.
//   - tvalid & tready with no completion: tvalid<=0. tdata holds while tvalid=1 & tready=0.
// - IDLE may accept a new trigger the cycle after completion, independent of output state.
// CONFIGURATION
// - DECODER_CONFIDENCE_EN defined:
//   - Adds output m00_axis_tuser [DATA_WIDTH+$clog2(WINDOW)-1:0] = minimum |acc_final| over all packet bits.
//     The magnitude saturates at the port maximum.
//   - tuser is loaded and held with tdata; reset 0.
// - DECODER_CONFIDENCE_EN undefined: port absent, no min tracking logic.
// TESTING
// - Trigger(pol=0), 3 junk + 128 symbols of +1000/-1000 pattern 0xA5.. repeated, tready=1
//   -> one beat tdata=0xA5A5..A5, tvalid 1 cycle, tlast=1.
// - Same stimulus, trigger_polarity=1 -> tdata=0x5A5A..5A.
// - Random tvalid gaps (50% duty) -> identical tdata to the gap-free run.
// - Samples outside window = -30000, inside = +100 -> all bits 1 (window-only integration).
// - Two back-to-back packets, tready=0 throughout -> first held, second dropped, overflow=1.
//   Raise tready -> first accepted, tvalid=0.
// - abort at bit 60 -> no output, busy=0 next cycle; retrigger decodes normally.
//   Async reset mid-packet -> all outputs 0 immediately.

Source files
------------

// File: rtl/bpsk_packet_decoder.sv
// -----------------------------------------------------------------------------
// bpsk_packet_decoder
//
// Purpose:
//   BPSK packet decoder fed by the carrier/phase-recovery path. After a sync
//   trigger it skips START_OFFSET valid samples. It then integrates a centred
//   WINDOW of every symbol (integrate-and-dump) and slices the sign of each sum
//   to one bit. PACKET_LENGTH bits make up one AXIS word, with the first bit in
//   the MSB. A one-deep holding register absorbs m00 backpressure. A packet
//   that completes while that register is still full is dropped, and the
//   sticky overflow flag is set.
//
// Optional feature:
//   DECODER_CONFIDENCE_EN - when defined, adds m00_axis_tuser. It carries the
//   minimum |integrator sum| seen over all bits of the packet, saturated at the
//   port maximum. It is loaded and held together with m00_axis_tdata.
//
// Ports:
//   s00_axis_aclk      clock
//   s00_axis_areset    asynchronous active-high reset
//   s00_axis_tdata     signed baseband sample
//   s00_axis_tvalid    sample valid; only valid cycles advance the decoder
//   s00_axis_tlast     ignored
//   s00_axis_tready    always 1
//   trigger_valid      1-cycle start pulse; honoured only in IDLE
//   trigger_polarity   1 inverts every decoded bit of the packet
//   abort              drops the packet in progress
//   m00_axis_tdata     decoded packet
//   m00_axis_tvalid    packet valid
//   m00_axis_tready    downstream ready
//   m00_axis_tlast     equals m00_axis_tvalid (one beat per packet)
//   m00_axis_tstrb     all ones
//   m00_axis_tuser     confidence (only with DECODER_CONFIDENCE_EN)
//   overflow           sticky: a completed packet was dropped
//   busy               decoder is not IDLE
// -----------------------------------------------------------------------------
module bpsk_packet_decoder #(
  parameter int DATA_WIDTH         = 16,
  parameter int PACKET_LENGTH      = 128,
  parameter int SAMPLES_PER_SYMBOL = 32,
  parameter int WINDOW             = 16,
  parameter int START_OFFSET       = 3
) (
  input  logic                                 s00_axis_aclk,
  input  logic                                 s00_axis_areset,
  input  logic [DATA_WIDTH-1:0]                s00_axis_tdata,
  input  logic                                 s00_axis_tvalid,
  input  logic                                 s00_axis_tlast,
  output logic                                 s00_axis_tready,
  input  logic                                 trigger_valid,
  input  logic                                 trigger_polarity,
  input  logic                                 abort,
  output logic [PACKET_LENGTH-1:0]             m00_axis_tdata,
  output logic                                 m00_axis_tvalid,
  input  logic                                 m00_axis_tready,
  output logic                                 m00_axis_tlast,
  output logic [PACKET_LENGTH/8-1:0]           m00_axis_tstrb,
`ifdef DECODER_CONFIDENCE_EN
  output logic [DATA_WIDTH+$clog2(WINDOW)-1:0] m00_axis_tuser,
`endif
  output logic                                 overflow,
  output logic                                 busy
);

  localparam int ACC_W = DATA_WIDTH + $clog2(WINDOW) + 1;
  localparam int MAG_W = ACC_W - 1;
  localparam int SW    = $clog2(SAMPLES_PER_SYMBOL);
  localparam int BW    = $clog2(PACKET_LENGTH);

  localparam logic [SW-1:0] WIN_LO    = SW'(SAMPLES_PER_SYMBOL/2 - WINDOW/2);
  localparam logic [SW-1:0] WIN_HI    = SW'(SAMPLES_PER_SYMBOL/2 + WINDOW/2 - 1);
  localparam logic [SW-1:0] S_LAST    = SW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [BW-1:0] B_LAST    = BW'(PACKET_LENGTH - 1);
  localparam logic [7:0]    SKIP_LAST = 8'((START_OFFSET == 0) ? 0 : START_OFFSET - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    RECORD = 2'd2
  } state_t;

  state_t                    state;
  logic [7:0]                skip_cnt;
  logic [SW-1:0]             samp_cnt;
  logic [BW-1:0]             bit_cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [PACKET_LENGTH-1:0]  shift_reg;
  logic                      pol;

  logic                      in_window;
  logic signed [ACC_W-1:0]   sample_ext;
  logic signed [ACC_W-1:0]   acc_final;
  logic                      symbol_end;
  logic                      new_bit;
  logic                      packet_done;
  logic [PACKET_LENGTH-1:0]  packet_word;

  // Sum including the current sample, so the slicer sees the window's last
  // sample even when the window ends on the final sample of the symbol.
  assign in_window   = (samp_cnt >= WIN_LO) && (samp_cnt <= WIN_HI);
  assign sample_ext  = {{(ACC_W-DATA_WIDTH){s00_axis_tdata[DATA_WIDTH-1]}}, s00_axis_tdata};
  assign acc_final   = acc + (in_window ? sample_ext : '0);
  assign symbol_end  = (state == RECORD) && s00_axis_tvalid && (samp_cnt == S_LAST);
  // acc_final >= 0 is a clear sign bit; polarity resolves the 180-degree ambiguity.
  assign new_bit     = ~acc_final[ACC_W-1] ^ pol;
  // abort wins over a same-cycle completion.
  assign packet_done = symbol_end && (bit_cnt == B_LAST) && !abort;
  assign packet_word = {shift_reg[PACKET_LENGTH-2:0], new_bit};

`ifdef DECODER_CONFIDENCE_EN
  logic [ACC_W-1:0] acc_abs;
  logic [MAG_W-1:0] cur_mag;
  logic [MAG_W-1:0] min_mag;
  logic [MAG_W-1:0] min_next;

  // |most negative sum| does not fit in MAG_W bits, so it saturates.
  assign acc_abs  = acc_final[ACC_W-1] ? $unsigned(-acc_final) : $unsigned(acc_final);
  assign cur_mag  = acc_abs[ACC_W-1] ? '1 : acc_abs[MAG_W-1:0];
  assign min_next = (cur_mag < min_mag) ? cur_mag : min_mag;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and integrate-and-dump datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      samp_cnt  <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      shift_reg <= '0;
      pol       <= 1'b0;
`ifdef DECODER_CONFIDENCE_EN
      min_mag   <= '1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (trigger_valid) begin
            pol       <= trigger_polarity;
            skip_cnt  <= '0;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            acc       <= '0;
            shift_reg <= '0;
`ifdef DECODER_CONFIDENCE_EN
            min_mag   <= '1;
`endif
            state     <= (START_OFFSET == 0) ? RECORD : SKIP;
          end
        end

        SKIP: begin
          if (abort) begin
            state <= IDLE;
          end else if (s00_axis_tvalid) begin
            if (skip_cnt == SKIP_LAST) state <= RECORD;
            else                       skip_cnt <= skip_cnt + 1'b1;
          end
        end

        RECORD: begin
          if (abort) begin
            state <= IDLE;
          end else if (s00_axis_tvalid) begin
            if (samp_cnt == S_LAST) begin
              samp_cnt  <= '0;
              acc       <= '0;
              shift_reg <= packet_word;
`ifdef DECODER_CONFIDENCE_EN
              min_mag   <= min_next;
`endif
              if (bit_cnt == B_LAST) state <= IDLE;
              else                   bit_cnt <= bit_cnt + 1'b1;
            end else begin
              samp_cnt <= samp_cnt + 1'b1;
              acc      <= acc_final;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // One-deep output holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
      overflow        <= 1'b0;
`ifdef DECODER_CONFIDENCE_EN
      m00_axis_tuser  <= '0;
`endif
    end else if (packet_done) begin
      // The slot is free when empty or draining this very cycle.
      if (!m00_axis_tvalid || m00_axis_tready) begin
        m00_axis_tdata  <= packet_word;
        m00_axis_tvalid <= 1'b1;
`ifdef DECODER_CONFIDENCE_EN
        m00_axis_tuser  <= min_next;
`endif
      end else begin
        overflow <= 1'b1;
      end
    end else if (m00_axis_tvalid && m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tlast  = m00_axis_tvalid;
  assign m00_axis_tstrb  = '1;
  assign busy            = (state != IDLE);

  // tlast carries no framing here; the MSB of the shift register is never
  // read because the word is built from the lower bits plus the new bit.
  logic [1:0] unused_bits;
  assign unused_bits = {s00_axis_tlast, shift_reg[PACKET_LENGTH-1]};

endmodule

// File: tb/tb_bpsk_packet_decoder.sv
module tb_bpsk_packet_decoder;

  localparam int DW  = 16;
  localparam int PL  = 128;
  localparam int SPS = 32;
  localparam int W   = 16;
  localparam int OFF = 3;
  localparam int LO  = SPS/2 - W/2;
  localparam int HI  = SPS/2 + W/2 - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      s_tdata;
  logic               s_tvalid;
  logic               s_tlast;
  logic               s_tready;
  logic               trig;
  logic               trig_pol;
  logic               abort;
  logic [PL-1:0]      m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic               m_tlast;
  logic [PL/8-1:0]    m_tstrb;
  logic               overflow;
  logic               busy;

  always #5 clk = ~clk;

  bpsk_packet_decoder #(
    .DATA_WIDTH(DW), .PACKET_LENGTH(PL), .SAMPLES_PER_SYMBOL(SPS),
    .WINDOW(W), .START_OFFSET(OFF)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_areset(rst),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast),
    .s00_axis_tready(s_tready),
    .trigger_valid(trig),
    .trigger_polarity(trig_pol),
    .abort(abort),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tready(m_tready),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tstrb(m_tstrb),
    .overflow(overflow),
    .busy(busy)
  );

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [PL-1:0] exp_q[$];
  int            samp[$];

  task automatic check(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted beat must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got %h expected no beat", m_tdata);
      end else begin
        check("beat_tdata", m_tdata, exp_q.pop_front());
      end
      check("beat_tlast", PL'(m_tlast), PL'(1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Reference: per symbol k, sum the window samples after the skip region,
  // bit = (sum >= 0) ^ polarity, first symbol in the MSB.
  function automatic logic [PL-1:0] model_word(input bit pol);
    logic [PL-1:0] w;
    longint        sum;
    w = '0;
    for (int k = 0; k < PL; k++) begin
      sum = 0;
      for (int j = LO; j <= HI; j++) sum += samp[OFF + k*SPS + j];
      w[PL-1-k] = (sum >= 0) ^ pol;
    end
    return w;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  // kind 0: 0xA5 pattern at +/-1000; kind 1: -30000 outside window, +100 inside;
  // kind 2: random noise around a random bias, some symbols with a zero window sum.
  task automatic build(input int kind);
    logic [7:0] pat;
    int         bias, v;
    bit         zero_sym;
    pat = 8'hA5;
    samp.delete();
    for (int i = 0; i < OFF; i++) samp.push_back(rnd(-30000, 30000));
    for (int k = 0; k < PL; k++) begin
      bias     = rnd(-300, 300);
      v        = rnd(1, 2000);
      zero_sym = ($urandom_range(7) == 0);
      for (int j = 0; j < SPS; j++) begin
        case (kind)
          0:       samp.push_back(pat[7 - (k % 8)] ? 1000 : -1000);
          1:       samp.push_back((j >= LO && j <= HI) ? 100 : -30000);
          default: begin
            if (zero_sym && j >= LO && j <= HI) samp.push_back((j % 2 == 0) ? v : -v);
            else                                samp.push_back(bias + rnd(-1500, 1500));
          end
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input bit pol);
    trig     = 1'b1;
    trig_pol = pol;
    s_tvalid = 1'b0;
    step();
    trig     = 1'b0;
    trig_pol = 1'b0;
  endtask

  task automatic drive(input int first, input int last, input int gap_pct);
    for (int i = first; i <= last; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_tvalid = 1'b0;
        s_tdata  = DW'($urandom);
        step();
      end
      s_tvalid = 1'b1;
      s_tdata  = DW'(samp[i]);
      step();
    end
    s_tvalid = 1'b0;
  endtask

  // Full packet with an empty holding register and tready=1: word one cycle
  // after the final sample, gone one cycle later.
  task automatic full_packet(input int kind, input bit pol, input int gap_pct);
    logic [PL-1:0] exp;
    build(kind);
    case (kind)
      0:       exp = pol ? {16{8'h5A}} : {16{8'hA5}};
      1:       exp = pol ? '0 : '1;
      default: exp = model_word(pol);
    endcase
    exp_q.push_back(exp);
    trigger(pol);
    @(negedge clk);
    check("busy_after_trigger", PL'(busy), PL'(1));
    step();
    drive(0, samp.size() - 1, gap_pct);
    @(negedge clk);
    check("latency_tvalid", PL'(m_tvalid), PL'(1));
    check("busy_after_done", PL'(busy), PL'(0));
    step();
    @(negedge clk);
    check("tvalid_one_cycle", PL'(m_tvalid), PL'(0));
    step();
  endtask

  initial begin
    logic [PL-1:0] held;
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    trig     = 1'b0;
    trig_pol = 1'b0;
    abort    = 1'b0;
    m_tready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("reset_tvalid", PL'(m_tvalid), PL'(0));
    check("reset_tdata", m_tdata, '0);
    check("reset_overflow", PL'(overflow), PL'(0));
    check("reset_busy", PL'(busy), PL'(0));
    check("tready_const", PL'(s_tready), PL'(1));
    check("tstrb_ones", PL'(m_tstrb), PL'({(PL/8){1'b1}}));
    rst = 1'b0;
    step();

    full_packet(0, 1'b0, 0);     // 0xA5 pattern
    full_packet(0, 1'b1, 0);     // inverted polarity
    full_packet(0, 1'b0, 50);    // tvalid gaps
    full_packet(1, 1'b0, 0);     // window-only integration
    full_packet(2, $urandom_range(1), 0);
    full_packet(2, $urandom_range(1), 25);

    // Backpressure: first packet held, back-to-back second dropped.
    m_tready = 1'b0;
    build(2);
    held = model_word(1'b0);
    exp_q.push_back(held);
    trigger(1'b0);
    drive(0, samp.size() - 1, 0);
    @(negedge clk);
    check("hold_tvalid", PL'(m_tvalid), PL'(1));
    check("no_overflow_yet", PL'(overflow), PL'(0));
    step();
    build(0);
    trigger(1'b0);
    drive(0, samp.size() - 1, 0);
    @(negedge clk);
    check("overflow_set", PL'(overflow), PL'(1));
    check("hold_still_valid", PL'(m_tvalid), PL'(1));
    check("hold_tdata", m_tdata, held);
    step();
    m_tready = 1'b1;
    step();
    @(negedge clk);
    check("drained_tvalid", PL'(m_tvalid), PL'(0));
    step();

    // Abort in the middle of bit 60, then a normal retrigger.
    build(0);
    trigger(1'b0);
    drive(0, OFF + 60*SPS + 5, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", PL'(busy), PL'(0));
    step();
    drive(0, 2*SPS, 0);
    @(negedge clk);
    check("abort_no_output", PL'(m_tvalid), PL'(0));
    step();
    full_packet(2, 1'b1, 0);

    // Async reset with a held word and a packet in progress.
    m_tready = 1'b0;
    build(0);
    trigger(1'b0);
    drive(0, samp.size() - 1, 0);
    @(negedge clk);
    check("pre_reset_tvalid", PL'(m_tvalid), PL'(1));
    step();
    build(2);
    trigger(1'b0);
    drive(0, OFF + 40*SPS, 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tvalid", PL'(m_tvalid), PL'(0));
    check("async_rst_tdata", m_tdata, '0);
    check("async_rst_busy", PL'(busy), PL'(0));
    check("async_rst_overflow", PL'(overflow), PL'(0));
    step();
    step();
    rst      = 1'b0;
    m_tready = 1'b1;
    step();
    full_packet(0, 1'b0, 0);

    repeat (4) step();
    check("scoreboard_empty", PL'(exp_q.size()), PL'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
